// File: rtl/conv_capture_pkg.sv
// Shared constants and state encoding for the convolution frame-capture block.
package conv_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned IMG_H_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } capture_state_t;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_capture_if.sv
// Capture stream, host read port and status bundle for conv_capture.
// drop_cnt exists only when CONV_CAPTURE_DROPCNT_EN is defined.
interface conv_capture_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned COL_W  = 2,
  parameter int unsigned ROW_W  = 2
);
  logic              start;
  logic              valid_in;
  logic [PIX_W-1:0]  px_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
`ifdef CONV_CAPTURE_DROPCNT_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output start, valid_in, px_in, rd_en, rd_addr,
`ifdef CONV_CAPTURE_DROPCNT_EN
    input  drop_cnt,
`endif
    input  rd_data, rd_valid, busy, done, col, row
  );

  modport slave (
    input  start, valid_in, px_in, rd_en, rd_addr,
`ifdef CONV_CAPTURE_DROPCNT_EN
    output drop_cnt,
`endif
    output rd_data, rd_valid, busy, done, col, row
  );

endinterface

// File: rtl/conv_capture_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Out-of-range reads return zero; read-during-write returns the old word.
module conv_capture_ram #(
  parameter int unsigned Depth = 9,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_d, rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = (32'(raddr_i) < Depth) ? mem[raddr_i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_capture.sv
// Captures one (IMG_W-2)x(IMG_H-2) convolution output frame in raster order for host readback.
// Define CONV_CAPTURE_DROPCNT_EN to add a saturating counter of pixels dropped outside CAPTURE.
module conv_capture
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input logic            clk,
  input logic            rst,
  conv_capture_if.slave  cap_io
);

  localparam int unsigned OUT_W     = IMG_W - 2;
  localparam int unsigned OUT_H     = IMG_H - 2;
  localparam int unsigned FRAME_PIX = OUT_W * OUT_H;
  localparam int unsigned ADDR_W    = $clog2(FRAME_PIX);
  localparam int unsigned COL_W     = cnt_w(OUT_W);
  localparam int unsigned ROW_W     = cnt_w(OUT_H);

  capture_state_t    state_d, state_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q, base_ptr;
  logic [COL_W-1:0]  col_d, col_q, base_col;
  logic [ROW_W-1:0]  row_d, row_q, base_row;
  logic              rd_valid_q;
  logic              capturing;
  logic              we;

  // A start pulse rebases the counters so a coincident pixel lands at address 0.
  assign capturing = cap_io.start || (state_q == CAPTURE);
  assign base_ptr  = cap_io.start ? '0 : wr_ptr_q;
  assign base_col  = cap_io.start ? '0 : col_q;
  assign base_row  = cap_io.start ? '0 : row_q;
  assign we        = capturing && cap_io.valid_in;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    col_d    = col_q;
    row_d    = row_q;
    if (cap_io.start) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      col_d    = '0;
      row_d    = '0;
    end
    if (we) begin
      if (base_ptr == ADDR_W'(FRAME_PIX - 1)) begin
        state_d  = DONE;
        wr_ptr_d = '0;
        col_d    = '0;
        row_d    = '0;
      end else begin
        wr_ptr_d = base_ptr + 1'b1;
        if (base_col == COL_W'(OUT_W - 1)) begin
          col_d = '0;
          row_d = base_row + 1'b1;
        end else begin
          col_d = base_col + 1'b1;
          row_d = base_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rd_valid_q <= cap_io.rd_en;
    end
  end

  conv_capture_ram #(
    .Depth (FRAME_PIX),
    .Width (PIX_W),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (base_ptr),
    .wdata_i (cap_io.px_in),
    .re_i    (cap_io.rd_en),
    .raddr_i (cap_io.rd_addr),
    .rdata_o (cap_io.rd_data)
  );

  assign cap_io.rd_valid = rd_valid_q;
  assign cap_io.busy     = (state_q == CAPTURE);
  assign cap_io.done     = (state_q == DONE);
  assign cap_io.col      = col_q;
  assign cap_io.row      = row_q;

`ifdef CONV_CAPTURE_DROPCNT_EN
  logic [15:0] drop_cnt_d, drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cap_io.valid_in && !capturing && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign cap_io.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_conv_capture.sv
// Directed self-checking bench for conv_capture with a 5x5 image (3x3 output frame).
module tb_conv_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  conv_capture_if #(.PIX_W(8), .ADDR_W(4), .COL_W(2), .ROW_W(2)) cap_if ();

  conv_capture #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .cap_io (cap_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [7:0] px);
    cap_if.valid_in = 1'b1;
    cap_if.px_in    = px;
    tick();
    cap_if.valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    cap_if.start = 1'b1;
    tick();
    cap_if.start = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    cap_if.rd_en   = 1'b1;
    cap_if.rd_addr = addr;
    tick();
    cap_if.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(cap_if.rd_valid), 32'd1);
    chk(tag, 32'(cap_if.rd_data), 32'(exp));
  endtask

  initial begin
    cap_if.start    = 1'b0;
    cap_if.valid_in = 1'b0;
    cap_if.px_in    = '0;
    cap_if.rd_en    = 1'b0;
    cap_if.rd_addr  = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(cap_if.busy), 32'd0);
    chk("rst_done", 32'(cap_if.done), 32'd0);
    chk("rst_rd_valid", 32'(cap_if.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(cap_if.rd_data), 32'd0);
    chk("rst_col", 32'(cap_if.col), 32'd0);
    chk("rst_row", 32'(cap_if.row), 32'd0);
`ifdef CONV_CAPTURE_DROPCNT_EN
    chk("rst_drop", 32'(cap_if.drop_cnt), 32'd0);
`endif

    // Back-to-back frame of 10..18
    pulse_start();
    chk("b2b_busy", 32'(cap_if.busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      pix(8'(10 + i));
      if (i == 3) begin
        chk("b2b_col4", 32'(cap_if.col), 32'd1);
        chk("b2b_row4", 32'(cap_if.row), 32'd1);
      end
      if (i == 7) chk("b2b_done_early", 32'(cap_if.done), 32'd0);
    end
    chk("b2b_done", 32'(cap_if.done), 32'd1);
    chk("b2b_busy_off", 32'(cap_if.busy), 32'd0);
    chk("b2b_col_wrap", 32'(cap_if.col), 32'd0);
    chk("b2b_row_wrap", 32'(cap_if.row), 32'd0);
    for (int i = 0; i < 9; i++) rd_chk("b2b_rd", 4'(i), 8'(10 + i));
    tick();
    chk("rd_valid_drop", 32'(cap_if.rd_valid), 32'd0);

    // Gapped frame of 30..38
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      pix(8'(30 + i));
      chk("gap_col", 32'(cap_if.col), 32'((i + 1) % 3));
      chk("gap_row", 32'(cap_if.row), 32'(((i + 1) / 3) % 3));
      tick();
    end
    chk("gap_done", 32'(cap_if.done), 32'd1);
    for (int i = 0; i < 9; i++) rd_chk("gap_rd", 4'(i), 8'(30 + i));

    // Start coincident with first pixel, then restart after 4 pixels
    cap_if.start = 1'b1;
    pix(8'h55);
    cap_if.start = 1'b0;
    chk("coin_busy", 32'(cap_if.busy), 32'd1);
    chk("coin_col", 32'(cap_if.col), 32'd1);
    rd_chk("coin_rd0", 4'd0, 8'h55);
    pix(8'h61);
    pix(8'h62);
    pix(8'h63);
    pulse_start();
    chk("restart_col", 32'(cap_if.col), 32'd0);
    pix(8'h77);
    rd_chk("restart_rd0", 4'd0, 8'h77);
    rd_chk("restart_rd1", 4'd1, 8'h61);
    rd_chk("restart_rd3", 4'd3, 8'h63);

    // Reset mid-capture
    pulse_start();
    for (int i = 0; i < 4; i++) pix(8'(8'h81 + i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(cap_if.busy), 32'd0);
    chk("midrst_done", 32'(cap_if.done), 32'd0);
    chk("midrst_col", 32'(cap_if.col), 32'd0);
    pix(8'hEE);
    pix(8'hEE);
    chk("midrst_ign_busy", 32'(cap_if.busy), 32'd0);
    chk("midrst_ign_col", 32'(cap_if.col), 32'd0);
    rd_chk("midrst_rd2", 4'd2, 8'h83);
    rd_chk("midrst_rd0", 4'd0, 8'h81);
`ifdef CONV_CAPTURE_DROPCNT_EN
    chk("midrst_drop", 32'(cap_if.drop_cnt), 32'd2);
`endif

    // Drops in IDLE and DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) pix(8'hDD);
    pulse_start();
    for (int i = 0; i < 9; i++) pix(8'(8'h90 + i));
    for (int i = 0; i < 3; i++) pix(8'hCC);
    chk("drop_done", 32'(cap_if.done), 32'd1);
    chk("drop_col", 32'(cap_if.col), 32'd0);
    rd_chk("drop_rd0", 4'd0, 8'h90);
    rd_chk("drop_rd8", 4'd8, 8'h98);
`ifdef CONV_CAPTURE_DROPCNT_EN
    chk("drop_cnt8", 32'(cap_if.drop_cnt), 32'd8);
    cap_if.valid_in = 1'b1;
    repeat (70000) tick();
    cap_if.valid_in = 1'b0;
    chk("drop_sat", 32'(cap_if.drop_cnt), 32'hFFFF);
`endif

    // Read-during-write returns the old word; out-of-range reads return zero
    pulse_start();
    for (int i = 0; i < 4; i++) pix(8'h00);
    pulse_start();
    for (int i = 0; i < 3; i++) pix(8'h00);
    cap_if.rd_en   = 1'b1;
    cap_if.rd_addr = 4'd3;
    pix(8'hAA);
    cap_if.rd_en = 1'b0;
    chk("rdw_valid", 32'(cap_if.rd_valid), 32'd1);
    chk("rdw_old", 32'(cap_if.rd_data), 32'h00);
    rd_chk("rdw_new", 4'd3, 8'hAA);
    rd_chk("oob_rd9", 4'd9, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_capture.md
CONV_CAPTURE -- requirements
Module: conv_capture

Interface
- REQ-001: Parameter PIX_W, default 8, output pixel width of the convolution stream.
- REQ-002: Parameter IMG_W, default 128, input image width in pixels.
- REQ-003: Parameter IMG_H, default 128, input image height in rows.
- REQ-004: Localparams OUT_W = IMG_W-2, OUT_H = IMG_H-2, FRAME_PIX = OUT_W*OUT_H and ADDR_W = $clog2(FRAME_PIX) SHALL be derived from these parameters.
- REQ-005: clk  input  1  single clock; all logic on its rising edge.
- REQ-006: rst  input  1  reset, synchronous, active-high.
- REQ-007: start  input  1  one-cycle pulse that arms a frame capture.
- REQ-008: valid_in  input  1  convolution output pixel strobe.
- REQ-009: px_in  input  PIX_W  convolution output pixel.
- REQ-010: rd_en  input  1  host read request.
- REQ-011: rd_addr  input  ADDR_W  host read address, raster order.
- REQ-012: rd_data  output  PIX_W  read data.
- REQ-013: rd_valid  output  1  rd_data qualifier.
- REQ-014: busy  output  1  high while in CAPTURE.
- REQ-015: done  output  1  high while in DONE.
- REQ-016: col  output  $clog2(OUT_W)  column of the next pixel to be stored.
- REQ-017: row  output  $clog2(OUT_H)  row of the next pixel to be stored.
- REQ-018: drop_cnt  output  16  count of pixels discarded outside CAPTURE (present only when CONV_CAPTURE_DROPCNT_EN is defined).

Function
- REQ-019: FSM states SHALL be IDLE, CAPTURE and DONE.
- REQ-020: Transitions: IDLE->CAPTURE on start; CAPTURE->DONE on the accepted pixel at wr_ptr==FRAME_PIX-1; DONE->CAPTURE on start.
- REQ-021: In CAPTURE, each valid_in cycle SHALL write px_in to mem[wr_ptr] and increment wr_ptr, col and row.
- REQ-022: col SHALL wrap from OUT_W-1 to 0 and increment row; row SHALL wrap from OUT_H-1 to 0 together with wr_ptr wrapping to 0 on the transition to DONE.
- REQ-023: Entering CAPTURE SHALL clear wr_ptr, col and row to 0.
- REQ-024: If start and valid_in coincide, px_in SHALL be stored at address 0 and wr_ptr SHALL become 1.
- REQ-025: start asserted during CAPTURE SHALL restart the capture from address 0; earlier pixels become stale.
- REQ-026: valid_in asserted in IDLE or DONE SHALL be discarded with no memory write.
- REQ-027: Read latency SHALL be one cycle: rd_data and rd_valid are registered from rd_en and rd_addr; rd_valid SHALL equal rd_en delayed by one cycle.
- REQ-028: Reads SHALL be permitted in every state.
- REQ-029: A read and a write to the same address in the same cycle SHALL return the old contents.
- REQ-030: A read with rd_addr >= FRAME_PIX SHALL return 0 with rd_valid=1.
- REQ-031: Pixel data SHALL be stored unmodified, with no arithmetic applied.

Reset
- REQ-032: While rst is high: state=IDLE; wr_ptr, col, row, rd_data, rd_valid, busy, done and drop_cnt SHALL be 0.
- REQ-033: Memory contents SHALL NOT be cleared by reset.
- REQ-034: Reset mid-CAPTURE SHALL abort the frame with no further writes.
- REQ-035: Reset SHALL take priority over start.

Configuration
- REQ-036: When CONV_CAPTURE_DROPCNT_EN is defined, drop_cnt SHALL increment, saturating at 0xFFFF, for every valid_in cycle in IDLE or DONE.
- REQ-037: drop_cnt SHALL clear only on rst.
- REQ-038: When CONV_CAPTURE_DROPCNT_EN is undefined, the drop_cnt port and its logic SHALL be absent and all other behaviour is identical.

Structure
- REQ-039: Package conv_pkg SHALL hold the default PIX_W/IMG_W/IMG_H constants and the capture_state_t enum (IDLE, CAPTURE, DONE).
- REQ-040: Storage SHALL be one sub-module, conv_capture_ram: simple dual-port, one write port and one registered read port, depth FRAME_PIX, width PIX_W.

Verification
- REQ-041: IMG_W=IMG_H=5 (FRAME_PIX=9); start, then 9 pixels 10..18 back-to-back -> done=1 the cycle after the 9th; reads of addresses 0..8 return 10..18 one cycle after rd_en.
- REQ-042: Same setup with valid_in gapped every other cycle -> identical memory contents; col/row step 0..2 and 0..2.
- REQ-043: start coincident with first pixel 0x55 -> mem[0]=0x55, wr_ptr=1; start issued again after 4 pixels -> the next pixel lands at address 0.
- REQ-044: Five valid_in pulses in IDLE and three in DONE -> no writes, drop_cnt=8 (macro defined); force 70000 drops -> drop_cnt=0xFFFF.
- REQ-045: rst for one cycle after 4 pixels -> busy=0, done=0, state IDLE; subsequent valid_in is ignored; a read of address 2 still returns the old pixel.
- REQ-046: Same-cycle read/write of address 3 (old 0x00, new 0xAA) -> rd_data=0x00; a re-read returns 0xAA; rd_addr=9 -> rd_data=0.
